// File: rtl/seq_alu_pkg.sv
// ============================================================================
// Module   : seq_alu_pkg
// Purpose  : Opcodes, FSM states and helpers shared by the seq_alu files.
//            Optional feature macro: SEQ_ALU_DIV_EN (iterative divider).
// Revision : 1.0
// ============================================================================
`default_nettype none

package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_NOP  = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SLTU = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_SRA  = 4'b1010,
        OP_MULU = 4'b1100,
        OP_DIVU = 4'b1101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_multicycle(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
        return (op == OP_MULU) || (op == OP_DIVU);
`else
        return (op == OP_MULU);
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_alu_muldiv.sv
// ============================================================================
// Module   : seq_alu_muldiv
// Purpose  : Iterative shift-add multiplier and, with SEQ_ALU_DIV_EN, a
//            restoring divider; one bit per cycle, start/done pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
`ifdef SEQ_ALU_DIV_EN
    input  logic             div_i,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH:0]   add_d;
`ifdef SEQ_ALU_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   sub_d;
`endif

    // lo/hi outputs are the result of the current step, so the top can
    // capture the finished value on the same edge that retires the last bit.
    always_comb begin
        add_d = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        hi_d  = add_d[WIDTH:1];
        lo_d  = {add_d[0], lo_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
        sub_d = {hi_q, lo_q[WIDTH-1]} - {1'b0, b_q};
        if (div_q) begin
            if (!sub_d[WIDTH]) begin
                hi_d = sub_d[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    assign done_o = busy_q && (cnt_q == LAST);
    assign lo_o   = lo_d;
    assign hi_o   = hi_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
`ifdef SEQ_ALU_DIV_EN
            div_q  <= 1'b0;
`endif
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= a_i;
            b_q    <= b_i;
`ifdef SEQ_ALU_DIV_EN
            div_q  <= div_i;
`endif
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module   : seq_alu
// Purpose  : Registered valid/ready ALU with flags and iterative MULU/DIVU.
//            Optional feature macro: SEQ_ALU_DIV_EN (enables DIVU).
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_alu
    import seq_alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             zf,
    output logic             nf,
    output logic             cf,
    output logic             vf,
    output logic             err
);

    state_e           state_q;
    logic [WIDTH-1:0] res_q, res_hi_q;
    logic             zf_q, nf_q, cf_q, vf_q, err_q;

    logic [WIDTH-1:0] res_d, res_hi_d;
    logic             cf_d, vf_d, err_d;
    logic [WIDTH:0]   sum_w, diff_w;
    logic [SHW-1:0]   sh_w;
    logic             long_w, start_w, md_done_w;
    logic [WIDTH-1:0] md_lo_w, md_hi_w;

    assign sum_w  = {1'b0, a} + {1'b0, b};
    assign diff_w = {1'b0, a} - {1'b0, b};
    assign sh_w   = b[SHW-1:0];

    // A zero divisor short-circuits the divider onto the single-cycle path.
    assign long_w  = is_multicycle(op) && !((op == OP_DIVU) && (b == '0));
    assign start_w = in_valid && (state_q == ST_IDLE) && long_w;

    always_comb begin
        res_d    = '0;
        res_hi_d = '0;
        cf_d     = 1'b0;
        vf_d     = 1'b0;
        err_d    = 1'b0;
        case (op)
            OP_AND:  res_d = a & b;
            OP_OR:   res_d = a | b;
            OP_XOR:  res_d = a ^ b;
            OP_NOP:  res_d = '0;
            OP_ADD: begin
                res_d = sum_w[WIDTH-1:0];
                cf_d  = sum_w[WIDTH];
                vf_d  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_d = diff_w[WIDTH-1:0];
                cf_d  = diff_w[WIDTH];
                vf_d  = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, diff_w[WIDTH]};
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  res_d = a << sh_w;
            OP_SRL:  res_d = a >> sh_w;
            OP_SRA:  res_d = $signed(a) >>> sh_w;
`ifdef SEQ_ALU_DIV_EN
            OP_DIVU: begin
                res_d    = '1;
                res_hi_d = a;
                err_d    = 1'b1;
            end
`endif
            default: err_d = 1'b1;
        endcase
    end

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_w),
`ifdef SEQ_ALU_DIV_EN
        .div_i   (op == OP_DIVU),
`endif
        .a_i     (a),
        .b_i     (b),
        .done_o  (md_done_w),
        .lo_o    (md_lo_w),
        .hi_o    (md_hi_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            res_q    <= '0;
            res_hi_q <= '0;
            zf_q     <= 1'b0;
            nf_q     <= 1'b0;
            cf_q     <= 1'b0;
            vf_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (long_w) begin
                            state_q <= ST_BUSY;
                        end else begin
                            state_q  <= ST_DONE;
                            res_q    <= res_d;
                            res_hi_q <= res_hi_d;
                            zf_q     <= (res_d == '0);
                            nf_q     <= res_d[WIDTH-1];
                            cf_q     <= cf_d;
                            vf_q     <= vf_d;
                            err_q    <= err_d;
                        end
                    end
                end
                ST_BUSY: begin
                    if (md_done_w) begin
                        state_q  <= ST_DONE;
                        res_q    <= md_lo_w;
                        res_hi_q <= md_hi_w;
                        zf_q     <= (md_lo_w == '0);
                        nf_q     <= md_lo_w[WIDTH-1];
                        cf_q     <= 1'b0;
                        vf_q     <= 1'b0;
                        err_q    <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign res       = res_q;
    assign res_hi    = res_hi_q;
    assign zf        = zf_q;
    assign nf        = nf_q;
    assign cf        = cf_q;
    assign vf        = vf_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// Module   : tb_seq_alu
// Purpose  : Directed self-checking bench for seq_alu (WIDTH=32); expected
//            DIVU results follow SEQ_ALU_DIV_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'h0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] res, res_hi;
    logic         zf, nf, cf, vf, err;

    int n_tests = 0;
    int n_fail  = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .res_hi    (res_hi),
        .zf        (zf),
        .nf        (nf),
        .cf        (cf),
        .vf        (vf),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flags are compared packed as {zf,nf,cf,vf,err}.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int exp_lat, input logic [W-1:0] e_res,
                          input logic [W-1:0] e_hi, input logic [4:0] e_fl);
        int lat;
        logic rdy_seen;
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 4'hE;
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            rdy_seen |= in_ready;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 80'(lat), 80'(exp_lat));
        check({tag, " ready_while_busy"}, 80'(rdy_seen), 80'(0));
        check({tag, " res"}, 80'(res), 80'(e_res));
        check({tag, " res_hi"}, 80'(res_hi), 80'(e_hi));
        check({tag, " flags"}, 80'({zf, nf, cf, vf, err}), 80'(e_fl));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " release"}, 80'({in_ready, out_valid}), 80'(2'b10));
    endtask

    initial begin
        #12;
        check("reset_state", {in_ready, out_valid, res, res_hi, zf, nf, cf, vf, err},
              {1'b1, 1'b0, 64'd0, 5'd0});
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h1,        1, 32'h80000000, 0, 5'b01010);
        run_op("add_carry",4'b0010, 32'hFFFFFFFF, 32'h1,        1, 32'h0,        0, 5'b10100);
        run_op("sub",      4'b0110, 32'd3,        32'd5,        1, 32'hFFFFFFFE, 0, 5'b01100);
        run_op("sub_ovf",  4'b0110, 32'h80000000, 32'h1,        1, 32'h7FFFFFFF, 0, 5'b00010);
        run_op("slt",      4'b0111, 32'hFFFFFFFF, 32'h1,        1, 32'h1,        0, 5'b00000);
        run_op("sltu",     4'b0101, 32'hFFFFFFFF, 32'h1,        1, 32'h0,        0, 5'b10000);
        run_op("and",      4'b0000, 32'h0000F0F0, 32'h0000FF00, 1, 32'h0000F000, 0, 5'b00000);
        run_op("or",       4'b0001, 32'h0000000F, 32'h000000F0, 1, 32'h000000FF, 0, 5'b00000);
        run_op("xor",      4'b0100, 32'hFFFF0000, 32'hFF00FF00, 1, 32'h00FFFF00, 0, 5'b00000);
        run_op("nop",      4'b0011, 32'h12345678, 32'h9,        1, 32'h0,        0, 5'b10000);
        run_op("sll",      4'b1000, 32'h1,        32'h3F,       1, 32'h80000000, 0, 5'b01000);
        run_op("srl",      4'b1001, 32'h80000000, 32'h23,       1, 32'h10000000, 0, 5'b00000);
        run_op("sra",      4'b1010, 32'h80000000, 32'h24,       1, 32'hF8000000, 0, 5'b01000);
        run_op("undef",    4'b1111, 32'h5,        32'h6,        1, 32'h0,        0, 5'b10001);
        run_op("mulu_max", 4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h1, 32'hFFFFFFFE, 5'b00000);
        run_op("mulu",     4'b1100, 32'd12345,    32'd678,      33, 32'h007FB6F6, 0, 5'b00000);
`ifdef SEQ_ALU_DIV_EN
        run_op("divu",     4'b1101, 32'd100,      32'd7,        33, 32'd14, 32'd2, 5'b00000);
        run_op("divu_zero",4'b1101, 32'd100,      32'd0,        1, 32'hFFFFFFFF, 32'd100, 5'b01001);
`else
        run_op("divu_off", 4'b1101, 32'd100,      32'd7,        1, 32'h0,        0, 5'b10001);
`endif

        // Result held while the consumer stalls.
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'b0010;
        a = 32'd1;
        b = 32'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold", {in_ready, out_valid, res, zf, nf, cf, vf, err},
                  {1'b0, 1'b1, 32'd3, 5'b00000});
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold_release", {in_ready, out_valid}, 2'b10);

        // Reset asserted while the multiplier is busy.
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'b1100;
        a = 32'hFFFFFFFF;
        b = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_reset", {in_ready, out_valid, res, res_hi, zf, nf, cf, vf, err},
              {1'b1, 1'b0, 64'd0, 5'd0});
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                seen |= out_valid | ~in_ready;
            end
            check("abort_no_result", seen, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
